vga_timing_gen: RTL and testbench

Raster timing generator for the maze display, clocked by the 25 MHz pixel clock from the clock wizard. Produces horizontal/vertical sync, an active-video qualifier, pixel coordinates and line/frame strobes for the maze renderer. Counters run only while `en` is high; `en` is driven by the clock-wizard lock indication so that no partial raster is emitted from an unstable clock.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_axis_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster path.
// Optional frame counter is enabled by VGA_FRAME_CNT_EN.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF =
        H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF =
        V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_MAX_DEF =
        (H_TOTAL_DEF > V_TOTAL_DEF) ? H_TOTAL_DEF : V_TOTAL_DEF;

    // Wide enough for either axis counter.
    localparam int CNT_W = $clog2(CNT_MAX_DEF);

    // Sync bundle carried alongside pixels by renderer stages.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } vga_sync_t;

    // True when v lies inside the closed range [lo, hi].
    function automatic logic in_span(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter for one raster axis.
// Steps on en && inc; wrap flags the step that returns to zero.
import vga_pkg::*;

module vga_axis_counter #(
    parameter int N = 800,
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = inc && (count == LAST);

    // Advance on each qualified increment, folding back to 0 at N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && inc) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, active-video, coordinates and strobes.
// Optional 16-bit frame counter port under VGA_FRAME_CNT_EN.
import vga_pkg::*;

module vga_timing_gen #(
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int H_FP          = H_FP_DEF,
    parameter int H_SYNC        = H_SYNC_DEF,
    parameter int H_BP          = H_BP_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_FP          = V_FP_DEF,
    parameter int V_SYNC        = V_SYNC_DEF,
    parameter int V_BP          = V_BP_DEF,
    parameter bit SYNC_ACT_HIGH = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);

    localparam logic [CNT_W-1:0] H_SYNC_LO =
        CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI =
        CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LO =
        CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI =
        CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Level driven on the sync pins when sync is not asserted.
    localparam logic SYNC_IDLE = ~SYNC_ACT_HIGH;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    vga_sync_t dec_sync;
    logic      dec_line;
    logic      dec_frame;

    vga_sync_t        sync_q;
    logic [CNT_W-1:0] pix_x_q;
    logic [CNT_W-1:0] pix_y_q;
    logic             line_q;
    logic             frame_q;

    vga_axis_counter #(
        .N (H_TOTAL),
        .W (CNT_W)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inc   (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .N (V_TOTAL),
        .W (CNT_W)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // Decode the current counter position into raw (active-high) timing.
    always_comb begin
        dec_sync          = '0;
        dec_line          = 1'b0;
        dec_frame         = 1'b0;
        dec_sync.video_on = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        dec_sync.hsync    = in_span(h_cnt, H_SYNC_LO, H_SYNC_HI);
        dec_sync.vsync    = in_span(v_cnt, V_SYNC_LO, V_SYNC_HI);
        dec_line          = (h_cnt == '0);
        dec_frame         = (h_cnt == '0) && (v_cnt == '0);
    end

    // Register all outputs together so they stay aligned one clock behind h/v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q.hsync    <= SYNC_IDLE;
            sync_q.vsync    <= SYNC_IDLE;
            sync_q.video_on <= 1'b0;
            pix_x_q         <= '0;
            pix_y_q         <= '0;
            line_q          <= 1'b0;
            frame_q         <= 1'b0;
        end else if (en) begin
            sync_q.hsync    <= dec_sync.hsync ? SYNC_ACT_HIGH : SYNC_IDLE;
            sync_q.vsync    <= dec_sync.vsync ? SYNC_ACT_HIGH : SYNC_IDLE;
            sync_q.video_on <= dec_sync.video_on;
            pix_x_q         <= h_cnt;
            pix_y_q         <= v_cnt;
            line_q          <= dec_line;
            frame_q         <= dec_frame;
        end
    end

    assign hsync       = sync_q.hsync;
    assign vsync       = sync_q.vsync;
    assign video_on    = sync_q.video_on;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count frames on the edge that raises frame_start; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (en && dec_frame) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened vertical raster.
// Horizontal timing is the full 800-clock line.
import vga_pkg::*;

module tb_vga_timing_gen;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 20;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    int passed;
    int total;

    vga_timing_gen #(
        .H_ACTIVE      (HA),
        .H_FP          (HF),
        .H_SYNC        (HS),
        .H_BP          (HB),
        .V_ACTIVE      (VA),
        .V_FP          (VF),
        .V_SYNC        (VS),
        .V_BP          (VB),
        .SYNC_ACT_HIGH (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int x, input int y, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (pix_x == CNT_W'(x) && pix_y == CNT_W'(y)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int ex;
        int ey;
        int errs;
        int hs_cnt;
        int hs_first;
        int vid_cnt;
        int vid_line;
        int ls_cnt;
        int vs_cnt;
        int vs_first;
        int fs_cnt;
        logic e_hs;
        logic e_vs;
        logic e_vid;

        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        en     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_video_on", 32'(video_on), 32'd0);
        chk("rst_line_start", 32'(line_start), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_pix_x", 32'(pix_x), 32'd0);
        chk("first_pix_y", 32'(pix_y), 32'd0);
        chk("first_frame_start", 32'(frame_start), 32'd1);
        chk("first_line_start", 32'(line_start), 32'd1);
        chk("first_video_on", 32'(video_on), 32'd1);

        ex = 0; ey = 0; errs = 0;
        hs_cnt = 0; hs_first = -1; vid_cnt = 0; vid_line = 0;
        ls_cnt = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            e_vid = (ex < HA) && (ey < VA);
            e_hs  = !((ex >= HA + HF) && (ex < HA + HF + HS));
            e_vs  = !((ey >= VA + VF) && (ey < VA + VF + VS));
            if (pix_x !== CNT_W'(ex) || pix_y !== CNT_W'(ey)) errs++;
            if (video_on !== e_vid || hsync !== e_hs) errs++;
            if (vsync !== e_vs) errs++;
            if (line_start !== (ex == 0)) errs++;
            if (frame_start !== (ex == 0 && ey == 0)) errs++;
            if (i < HT && hsync == 1'b0) begin
                if (hs_first < 0) hs_first = int'(pix_x);
                hs_cnt++;
            end
            if (i < HT && video_on) vid_line++;
            if (video_on) vid_cnt++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (vsync == 1'b0) begin
                if (vs_first < 0) vs_first = int'(pix_y);
                vs_cnt++;
            end
            if (ex == HT - 1) begin
                ex = 0;
                ey = (ey == VT - 1) ? 0 : ey + 1;
            end else begin
                ex++;
            end
            step();
        end
        chk("raster_track_errs", 32'(errs), 32'd0);
        chk("hsync_low_clocks", 32'(hs_cnt), 32'(HS));
        chk("hsync_first_x", 32'(hs_first), 32'(HA + HF));
        chk("video_on_per_line", 32'(vid_line), 32'(HA));
        chk("video_on_per_frame", 32'(vid_cnt), 32'(HA * VA));
        chk("line_starts_per_frame", 32'(ls_cnt), 32'(VT));
        chk("vsync_low_clocks", 32'(vs_cnt), 32'(VS * HT));
        chk("vsync_first_y", 32'(vs_first), 32'(VA + VF));
        chk("frame_starts_in_frame", 32'(fs_cnt), 32'd1);
        chk("wrap_frame_start", 32'(frame_start), 32'd1);
        chk("wrap_pix_x", 32'(pix_x), 32'd0);
        chk("wrap_pix_y", 32'(pix_y), 32'd0);

        run_to(0, 5, "reach_0_5");
        chk("pulse_pre_freeze", 32'(line_start), 32'd1);
        en = 1'b0;
        repeat (5) step();
        chk("pulse_held", 32'(line_start), 32'd1);
        en = 1'b1;
        step();
        chk("pulse_drop", 32'(line_start), 32'd0);
        chk("pulse_resume_x", 32'(pix_x), 32'd1);

        run_to(100, 10, "reach_100_10");
        en = 1'b0;
        repeat (37) step();
        chk("frz_pix_x", 32'(pix_x), 32'd100);
        chk("frz_pix_y", 32'(pix_y), 32'd10);
        chk("frz_video_on", 32'(video_on), 32'd1);
        chk("frz_hsync", 32'(hsync), 32'd1);
        chk("frz_line_start", 32'(line_start), 32'd0);
        en = 1'b1;
        step();
        chk("resume_pix_x", 32'(pix_x), 32'd101);
        chk("resume_pix_y", 32'(pix_y), 32'd10);

        run_to(700, VA + VF + 1, "reach_700_vs");
        chk("pre_rst_hsync", 32'(hsync), 32'd0);
        chk("pre_rst_vsync", 32'(vsync), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_pix_x", 32'(pix_x), 32'd0);
        chk("async_pix_y", 32'(pix_y), 32'd0);
        chk("async_hsync", 32'(hsync), 32'd1);
        chk("async_vsync", 32'(vsync), 32'd1);
        chk("async_video_on", 32'(video_on), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("restart_frame_start", 32'(frame_start), 32'd1);
        chk("restart_pix_x", 32'(pix_x), 32'd0);
        step();
        chk("restart_next_x", 32'(pix_x), 32'd1);

`ifdef VGA_FRAME_CNT_EN
        chk("fcnt_first", 32'(frame_cnt), 32'd1);
        dut.frame_cnt_q = 16'hFFFF;
        run_to(0, 0, "reach_next_frame");
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
        chk("fcnt_wrap_fs", 32'(frame_start), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
